wh_matrix_arb: RTL

//   Parametrised matrix (least-recently-served) arbiter with wormhole packet locking and a

---
 rtl/wh_matrix_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wh_matrix_arb.sv
// Least-recently-served matrix arbiter with wormhole locking: grant held from head to tail flit.
// Latency: combinational grant (0 cycles); priority and lock state update on the accepting edge.
// Backpressure: ack_i low holds the current grant and freezes all state; no preemption while locked.
module wh_matrix_arb #(
    parameter int unsigned IN_N    = 5,
    parameter int unsigned LOCK_EN = 1,
    localparam int         IDX_W   = (IN_N > 2) ? $clog2(IN_N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IN_N-1:0]  req_i,
    input  logic [IN_N-1:0]  last_i,
    input  logic             ack_i,
    output logic [IN_N-1:0]  grant_oh_o,
    output logic [IDX_W-1:0] grant_o,
    output logic             grant_vld_o,
    output logic             locked_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IN_N-1:0]   owner_oh;
    logic [IN_N-1:0]   win;
    logic              transfer;
    logic              last_g;
    logic              rel;

    // m[i][j] = 1 means i beats j; only the upper triangle holds flops
    logic              m [IN_N][IN_N];

    for (genvar i = 0; i < IN_N; i++) begin : g_row
        assign m[i][i] = 1'b0;
        for (genvar j = i + 1; j < IN_N; j++) begin : g_col
            logic cell_q;

            // On release the granted channel drops below every other channel
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cell_q <= 1'b1;
                end else if (rel) begin
                    if (grant_oh_o[i]) begin
                        cell_q <= 1'b0;
                    end else if (grant_oh_o[j]) begin
                        cell_q <= 1'b1;
                    end
                end
            end

            assign m[i][j] = cell_q;
            assign m[j][i] = ~cell_q;
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < IN_N; i++) begin
            logic beaten;
            beaten = 1'b0;
            for (int j = 0; j < IN_N; j++) begin
                if (req_i[j] && m[j][i]) begin
                    beaten = 1'b1;
                end
            end
            win[i] = req_i[i] & ~beaten;
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < IN_N; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
    end

    // While locked, only the owner can be granted, and only when it is requesting
    assign grant_oh_o  = (state_q == LOCKED) ? (owner_oh & req_i) : win;
    assign grant_vld_o = |grant_oh_o;

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (grant_oh_o[i]) begin
                grant_o = IDX_W'(i);
            end
        end
    end

    assign transfer = grant_vld_o & ack_i;
    assign last_g   = |(last_i & grant_oh_o);
    assign rel      = transfer & (last_g | (LOCK_EN == 0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer && !rel) begin
                        state_q <= LOCKED;
                        owner_q <= grant_o;
                    end
                end
                LOCKED: begin
                    if (rel) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign locked_o = (state_q == LOCKED);

endmodule
